instruction_encoder: RTL and testbench

Hardware assembler and program loader. Accepts one instruction per handshake as separate fields (type, code, registers, immediate), packs them into the processor's 32-bit instruction word, and writes the words to consecutive instruction-memory addresses from a programmable base. Range checking rejects illegal immediates. It sits between the debug/boot host interface and instruction memory, and produces exactly the encoding the pipeline's instruction decoder consumes.

---
 rtl/instruction_encoder.sv | 154 +++++++++++++++
 tb/tb_instruction_encoder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Instruction assembler and program loader: packs one field bundle per handshake into a
// 32-bit instruction word and streams the words to consecutive instruction-memory addresses.
module instruction_encoder #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [1:0]    funtype,
    input  logic [1:0]    funcode,
    input  logic [3:0]    rd,
    input  logic [3:0]    rs,
    input  logic [3:0]    rx,
    input  logic          selimm,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          done,
    output logic          err_illegal,
    output logic [7:0]    err_count,
    output logic [AW:0]   word_count,
    output logic          wrapped
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold last program's status
    // RUN   | accepting bundles and issuing writes
    // DRAIN | last bundle taken; waiting for its write to be acked
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [1:0] FT_REG      = 2'b00;
    localparam logic [1:0] FT_MEM      = 2'b01;
    localparam logic [1:0] FT_BRANCH   = 2'b10;
    localparam logic [1:0] FC_CACHE_WR = 2'b10;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   WC_ONE   = {{AW{1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nxt;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        ack_hit;
    logic        write_go;
    logic        reject;

    always_comb begin : encode
        enc_word  = '0;
        enc_legal = 1'b1;
        case (funtype)
            FT_REG: begin
                if (selimm) begin
                    enc_word  = {funtype, funcode, rd, rs, imm[18:0], 1'b1};
                    enc_legal = (imm[31:19] == '0);
                end else begin
                    enc_word = {funtype, funcode, rd, rs, rx, 16'b0};
                end
            end
            FT_MEM: begin
                // memory ops have no immediate form
                enc_word  = {funtype, funcode, rd, rs, rx, 16'b0};
                enc_legal = !selimm;
            end
            FT_BRANCH: begin
                enc_word  = {funtype, funcode, imm[27:0]};
                enc_legal = (imm[31:28] == '0);
            end
            default: begin
                if (funcode == FC_CACHE_WR) begin
                    enc_word  = {funtype, funcode, rd, imm[3:0], 20'b0};
                    enc_legal = (imm[31:4] == '0);
                end else begin
                    enc_word = {funtype, funcode, rd, 24'b0};
                end
            end
        endcase
    end

    // A pending write that is acked this edge frees the output register for a new word.
    assign in_ready = (state == RUN) && (!mem_we || mem_ack);
    assign accept   = in_valid && in_ready;
    assign ack_hit  = mem_we && mem_ack;
    assign write_go = accept && enc_legal;
    assign reject   = accept && !enc_legal;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin : fsm_next
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (!mem_we || mem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err_illegal <= 1'b0;
            err_count   <= '0;
            word_count  <= '0;
            wrapped     <= 1'b0;
        end else begin
            err_illegal <= reject;

            if (state == IDLE && start) begin
                mem_addr   <= base_addr;
                word_count <= '0;
                err_count  <= '0;
                wrapped    <= 1'b0;
            end else if (ack_hit) begin
                mem_addr   <= mem_addr + ADDR_ONE;
                word_count <= word_count + WC_ONE;
                if (&mem_addr) begin
                    wrapped <= 1'b1;
                end
            end

            if (write_go) begin
                mem_we    <= 1'b1;
                mem_wdata <= enc_word;
            end else if (ack_hit) begin
                mem_we <= 1'b0;
            end

            if (reject && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: AW=10 and AW=4 instances share stimulus and are checked
// against a field-level reference encoder and a write-address/count model.
module tb_instruction_encoder;

    localparam longint P16 = 65536;
    localparam longint P19 = 524288;
    localparam longint P20 = 1048576;
    localparam longint P24 = 16777216;
    localparam longint P28 = 268435456;
    localparam longint P30 = 1073741824;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  funtype;
    logic [1:0]  funcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rx;
    logic        selimm;
    logic [31:0] imm;
    logic        mem_ack;

    logic        in_ready10, mem_we10, busy10, done10, err_ill10, wrapped10;
    logic [9:0]  addr10;
    logic [31:0] wdata10;
    logic [7:0]  errc10;
    logic [10:0] wc10;

    logic        in_ready4, mem_we4, busy4, done4, err_ill4, wrapped4;
    logic [3:0]  addr4;
    logic [31:0] wdata4;
    logic [7:0]  errc4;
    logic [4:0]  wc4;

    always #5 clk = ~clk;

    instruction_encoder #(.AW(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready10), .in_last(in_last),
        .funtype(funtype), .funcode(funcode), .rd(rd), .rs(rs), .rx(rx),
        .selimm(selimm), .imm(imm), .mem_we(mem_we10), .mem_addr(addr10),
        .mem_wdata(wdata10), .mem_ack(mem_ack), .busy(busy10), .done(done10),
        .err_illegal(err_ill10), .err_count(errc10), .word_count(wc10), .wrapped(wrapped10)
    );

    instruction_encoder #(.AW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr[3:0]),
        .in_valid(in_valid), .in_ready(in_ready4), .in_last(in_last),
        .funtype(funtype), .funcode(funcode), .rd(rd), .rs(rs), .rx(rx),
        .selimm(selimm), .imm(imm), .mem_we(mem_we4), .mem_addr(addr4),
        .mem_wdata(wdata4), .mem_ack(mem_ack), .busy(busy4), .done(done4),
        .err_illegal(err_ill4), .err_count(errc4), .word_count(wc4), .wrapped(wrapped4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_words[$];
    int          got_addr10[$];
    int          got_addr4[$];
    int          commit_cyc[$];

    int m_addr10, m_addr4, m_wc, m_err;
    bit m_wrap10, m_wrap4;
    int cyc = 0;
    int ack_delay = 0;
    int pend_cnt = 0;
    int done_cnt = 0;
    int done4_cnt = 0;
    int done_cyc = 0;
    int last_commit_cyc = 0;
    int acc_cyc = 0;
    bit last_legal = 1'b1;
    bit          hold_valid = 1'b0;
    logic [9:0]  hold_addr;
    logic [31:0] hold_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoding built from the field layout with plain arithmetic.
    function automatic bit ref_encode(input int ft, input int fc, input int r_d, input int r_s,
                                      input int r_x, input bit sel, input longint im,
                                      output longint word);
        bit ok = 1'b1;
        word = ft * P30 + fc * P28;
        if (ft == 0 && sel) begin
            ok = (im < P19);
            word += r_d * P24 + r_s * P20 + (im % P19) * 2 + 1;
        end else if (ft <= 1) begin
            ok = !(ft == 1 && sel);
            word += r_d * P24 + r_s * P20 + r_x * P16;
        end else if (ft == 2) begin
            ok = (im < P28);
            word += im % P28;
        end else if (fc == 2) begin
            ok = (im < 16);
            word += r_d * P24 + (im % 16) * P20;
        end else begin
            word += r_d * P24;
        end
        return ok;
    endfunction

    // Memory model: decides ack, checks each committed write, checks held writes stay put.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mem_ack    = 1'b0;
            pend_cnt   = 0;
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check_val("hold_we", mem_we10, 1);
                check_val("hold_addr", addr10, hold_addr);
                check_val("hold_data", wdata10, hold_data);
            end
            if (ack_delay == 0) begin
                mem_ack = 1'b1;
            end else if (mem_we10) begin
                if (pend_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    pend_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    pend_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                pend_cnt = 0;
            end

            if (mem_we10 && mem_ack) begin
                check_val("we4", mem_we4, 1);
                check_val("pending_words", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check_val("wdata10", wdata10, e);
                    check_val("wdata4", wdata4, e);
                end
                check_val("addr10", addr10, m_addr10);
                check_val("addr4", addr4, m_addr4);
                got_words.push_back(wdata10);
                got_addr10.push_back(int'(addr10));
                got_addr4.push_back(int'(addr4));
                commit_cyc.push_back(cyc);
                if (m_addr10 == 1023) m_wrap10 = 1'b1;
                if (m_addr4 == 15) m_wrap4 = 1'b1;
                m_addr10 = (m_addr10 + 1) % 1024;
                m_addr4  = (m_addr4 + 1) % 16;
                m_wc++;
                last_commit_cyc = cyc;
                hold_valid = 1'b0;
            end else if (mem_we10) begin
                hold_valid = 1'b1;
                hold_addr  = addr10;
                hold_data  = wdata10;
            end else begin
                hold_valid = 1'b0;
            end

            if (done10) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done4) done4_cnt++;
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && mem_we10 && !mem_ack) check_val("stall_ready", in_ready10, 0);
    end

    task automatic check_reset();
        check_val("rst_in_ready", {in_ready10, in_ready4}, 0);
        check_val("rst_mem_we", {mem_we10, mem_we4}, 0);
        check_val("rst_addr", {addr10, addr4}, 0);
        check_val("rst_wdata", {wdata10, wdata4}, 0);
        check_val("rst_busy_done", {busy10, busy4, done10, done4}, 0);
        check_val("rst_err", {err_ill10, err_ill4, errc10, errc4}, 0);
        check_val("rst_wc_wrap", {wc10, wc4, wrapped10, wrapped4}, 0);
    endtask

    task automatic begin_prog(input int base, input int delay);
        @(negedge clk);
        #1;
        ack_delay = delay;
        pend_cnt  = 0;
        exp_q.delete();
        got_words.delete();
        got_addr10.delete();
        got_addr4.delete();
        commit_cyc.delete();
        m_addr10 = base % 1024;
        m_addr4  = base % 16;
        m_wc = 0;
        m_err = 0;
        m_wrap10 = 1'b0;
        m_wrap4 = 1'b0;
        done_cnt = 0;
        done4_cnt = 0;
        start = 1'b1;
        base_addr = base[9:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_after_start", {busy10, busy4}, 2'b11);
        check_val("ready_after_start", in_ready10, 1);
    endtask

    task automatic send(input int ft, input int fc, input int r_d, input int r_s, input int r_x,
                        input bit sel, input logic [31:0] im, input bit last);
        longint w;
        bit ok;
        int k = 0;
        funtype = ft[1:0];
        funcode = fc[1:0];
        rd = r_d[3:0];
        rs = r_s[3:0];
        rx = r_x[3:0];
        selimm = sel;
        imm = im;
        in_last = last;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!in_ready10 && k < 300);
        check_val("accept_ready", in_ready10, 1);
        check_val("ready4", in_ready4, in_ready10);
        if (!in_ready10) begin
            in_valid = 1'b0;
            return;
        end
        ok = ref_encode(ft, fc, r_d, r_s, r_x, sel, {32'b0, im}, w);
        if (ok) exp_q.push_back(w[31:0]);
        acc_cyc = cyc;
        last_legal = ok;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start = 1'b0;
        check_val("err_illegal", {err_ill10, err_ill4}, ok ? 2'b00 : 2'b11);
        if (!ok && m_err < 255) m_err++;
    endtask

    task automatic end_prog();
        int k = 0;
        while (done_cnt == 0 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val("done_seen", done_cnt, 1);
        if (last_legal) check_val("done_latency", done_cyc - last_commit_cyc, 1);
        else check_val("done_latency_illegal", done_cyc - acc_cyc, 2);
        @(negedge clk);
        #1;
        check_val("idle_busy", {busy10, busy4, done10, done4}, 0);
        check_val("done_pulses", {done_cnt[7:0], done4_cnt[7:0]}, 16'h0101);
        check_val("words_left", exp_q.size(), 0);
        check_val("word_count10", wc10, m_wc % 2048);
        check_val("word_count4", wc4, m_wc % 32);
        check_val("err_count", {errc10, errc4}, {m_err[7:0], m_err[7:0]});
        check_val("wrapped", {wrapped10, wrapped4}, {m_wrap10, m_wrap4});
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges[7];
        edges = '{32'd15, 32'd16, 32'h7FFFF, 32'h80000, 32'h0FFFFFFF, 32'h10000000, 32'h0};
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return edges[$urandom_range(0, 6)];
            2:       return $urandom;
            default: return $urandom % 32'h80000;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        funtype = '0;
        funcode = '0;
        rd = '0;
        rs = '0;
        rx = '0;
        selimm = 1'b0;
        imm = '0;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        // register and register-immediate forms, full-rate acks
        begin_prog(10'h010, 0);
        send(0, 0, 3, 1, 2, 0, 32'h0, 0);
        send(0, 1, 4, 5, 0, 1, 32'h12, 1);
        end_prog();
        check_val("t1_count", got_words.size(), 2);
        check_val("t1_w0", got_words[0], 32'h03120000);
        check_val("t1_w1", got_words[1], 32'h14500025);
        check_val("t1_a", {got_addr10[0][9:0], got_addr10[1][9:0]}, {10'h010, 10'h011});
        check_val("t1_b2b", commit_cyc[1] - commit_cyc[0], 1);
        check_val("t1_wc", wc10, 2);

        // branch, cache write, other kernel op
        begin_prog(10'h020, 0);
        send(2, 1, 0, 0, 0, 0, 32'h0000101, 0);
        send(3, 2, 2, 0, 0, 0, 32'hA, 0);
        send(3, 1, 7, 0, 0, 0, 32'h0, 1);
        end_prog();
        check_val("t2_w0", got_words[0], 32'h90000101);
        check_val("t2_w1", got_words[1], 32'hE2A00000);
        check_val("t2_w2", got_words[2], 32'hD7000000);

        // slow memory
        begin_prog(10'h040, 3);
        send(0, 2, 1, 2, 3, 0, 32'h0, 0);
        send(1, 3, 9, 8, 7, 0, 32'h0, 0);
        send(2, 0, 0, 0, 0, 0, 32'h0ABCDEF, 1);
        end_prog();
        check_val("t3_count", got_words.size(), 3);
        check_val("t3_gap", commit_cyc[1] - commit_cyc[0], 4);

        // illegal immediate between two legal bundles
        begin_prog(10'h080, 0);
        send(0, 0, 1, 1, 1, 0, 32'h0, 0);
        send(0, 0, 1, 2, 3, 1, 32'h80000, 0);
        send(0, 3, 2, 2, 2, 1, 32'h7FFFF, 1);
        end_prog();
        check_val("t4_errc", errc10, 1);
        check_val("t4_a", {got_addr10[0][9:0], got_addr10[1][9:0]}, {10'h080, 10'h081});

        // address wrap in both widths
        begin_prog(10'h3FF, 1);
        send(0, 0, 1, 2, 3, 0, 32'h0, 0);
        send(3, 0, 4, 0, 0, 0, 32'h0, 0);
        send(2, 2, 0, 0, 0, 0, 32'h5, 1);
        end_prog();
        check_val("t5_a4", {got_addr4[0][3:0], got_addr4[1][3:0], got_addr4[2][3:0]}, 12'hF01);
        check_val("t5_a10", {got_addr10[0][9:0], got_addr10[2][9:0]}, {10'h3FF, 10'h001});
        check_val("t5_wrap", {wrapped10, wrapped4}, 2'b11);

        // reset while a write is pending, then a clean restart
        begin_prog(10'h100, 1000);
        send(0, 0, 5, 5, 5, 0, 32'h0, 0);
        @(negedge clk);
        #1;
        check_val("t6_pending", mem_we10, 1);
        rst_n = 1'b0;
        #1;
        check_reset();
        exp_q.delete();
        ack_delay = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        begin_prog(10'h200, 0);
        send(0, 1, 1, 2, 3, 0, 32'h0, 0);
        start = 1'b1;
        base_addr = 10'h155;
        send(3, 3, 6, 0, 0, 0, 32'h0, 1);
        end_prog();
        check_val("t6_a", {got_addr10[0][9:0], got_addr10[1][9:0]}, {10'h200, 10'h201});

        // randomized programs
        repeat (25) begin
            int n;
            n = $urandom_range(1, 8);
            begin_prog($urandom_range(0, 1023), $urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 4) == 0) begin
                    start = 1'b1;
                    base_addr = 10'($urandom);
                end
                send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                     rand_imm(), i == n - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            end_prog();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
